alu_wb_demux: RTL and testbench

//  Write-back end of the ALU operand path. The operand mux selects IR/R5/R1/IDX/IDY onto the ALU input;

---
 rtl/alu_wb_demux.sv | 134 +++++++++++++
 tb/tb_alu_wb_demux.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_demux.sv
// Write-back demux for the ALU result path: accepts a result over valid/ready,
// holds it one cycle, commits it to IR/R5/R1/IDX/IDY, and counts legal commits.
module alu_wb_demux #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [2:0]       WBMUX,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             inc_idx,
  input  logic             inc_idy,
  output logic [WIDTH-1:0] IR_,
  output logic [WIDTH-1:0] R5_,
  output logic [WIDTH-1:0] R1_,
  output logic [WIDTH-1:0] IDX_,
  output logic [WIDTH-1:0] IDY_,
  output logic             wb_err,
  output logic [CNT_W-1:0] wr_count
);

  localparam logic [2:0] DEST_IR  = 3'b001;
  localparam logic [2:0] DEST_R5  = 3'b101;
  localparam logic [2:0] DEST_R1  = 3'b100;
  localparam logic [2:0] DEST_IDX = 3'b010;
  localparam logic [2:0] DEST_IDY = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] hold_data;
  logic [2:0]       hold_dest;
  logic             capture_c;
  logic             commit_c;
  logic             wr_ir_c;
  logic             wr_r5_c;
  logic             wr_r1_c;
  logic             wr_idx_c;
  logic             wr_idy_c;
  logic             illegal_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and capture/commit strobes
  always_comb begin
    state_next = state;
    capture_c  = 1'b0;
    commit_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (wb_valid && wb_ready) begin
          capture_c  = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD:   state_next = S_COMMIT;
      S_COMMIT: begin
        commit_c   = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Destination decode of the held word
  always_comb begin
    wr_ir_c   = 1'b0;
    wr_r5_c   = 1'b0;
    wr_r1_c   = 1'b0;
    wr_idx_c  = 1'b0;
    wr_idy_c  = 1'b0;
    illegal_c = 1'b0;
    if (commit_c) begin
      case (hold_dest)
        DEST_IR:  wr_ir_c   = 1'b1;
        DEST_R5:  wr_r5_c   = 1'b1;
        DEST_R1:  wr_r1_c   = 1'b1;
        DEST_IDX: wr_idx_c  = 1'b1;
        DEST_IDY: wr_idy_c  = 1'b1;
        default:  illegal_c = 1'b1;
      endcase
    end
  end

  // Hold register, handshake and error/count outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_dest <= '0;
      wb_ready  <= 1'b1;
      wb_err    <= 1'b0;
      wr_count  <= '0;
    end else begin
      if (capture_c) begin
        hold_data <= wb_data;
        hold_dest <= WBMUX;
      end
      wb_ready <= (state_next == S_IDLE);
      wb_err   <= illegal_c;
      if (commit_c && !illegal_c) wr_count <= wr_count + CNT_W'(1);
    end
  end

  // Destination registers; a commit to an index register overrides its increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      IR_  <= '0;
      R5_  <= '0;
      R1_  <= '0;
      IDX_ <= '0;
      IDY_ <= '0;
    end else begin
      if (wr_ir_c) IR_ <= hold_data;
      if (wr_r5_c) R5_ <= hold_data;
      if (wr_r1_c) R1_ <= hold_data;
      if (wr_idx_c)     IDX_ <= hold_data;
      else if (inc_idx) IDX_ <= IDX_ + WIDTH'(1);
      if (wr_idy_c)     IDY_ <= hold_data;
      else if (inc_idy) IDY_ <= IDY_ + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_alu_wb_demux.sv
// Directed bench for alu_wb_demux: hand-computed expectations checked with
// immediate assertions one cycle-step at a time.
module tb_alu_wb_demux;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  WBMUX;
  logic [15:0] wb_data;
  logic        inc_idx;
  logic        inc_idy;
  logic [15:0] IR_;
  logic [15:0] R5_;
  logic [15:0] R1_;
  logic [15:0] IDX_;
  logic [15:0] IDY_;
  logic        wb_err;
  logic [7:0]  wr_count;

  int checks;
  int passes;
  int fails;

  alu_wb_demux #(.WIDTH(16), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .WBMUX    (WBMUX),
    .wb_data  (wb_data),
    .inc_idx  (inc_idx),
    .inc_idy  (inc_idy),
    .IR_      (IR_),
    .R5_      (R5_),
    .R1_      (R1_),
    .IDX_     (IDX_),
    .IDY_     (IDY_),
    .wb_err   (wb_err),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [15:0] ir, input logic [15:0] r5,
                            input logic [15:0] r1, input logic [15:0] idx, input logic [15:0] idy);
    check({tag, ".IR"},  32'(IR_),  32'(ir));
    check({tag, ".R5"},  32'(R5_),  32'(r5));
    check({tag, ".R1"},  32'(R1_),  32'(r1));
    check({tag, ".IDX"}, 32'(IDX_), 32'(idx));
    check({tag, ".IDY"}, 32'(IDY_), 32'(idy));
  endtask

  // Wait (bounded) for ready, then transfer one word; returns after the accept edge + 1.
  task automatic send(input logic [2:0] dest, input logic [15:0] data);
    for (int i = 0; i < 10; i++) begin
      if (wb_ready) break;
      tick();
    end
    check("ready_before_send", 32'(wb_ready), 32'd1);
    WBMUX    = dest;
    wb_data  = data;
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
  endtask

  // Legal write: checks ready-low window and the N+2 commit latency.
  task automatic write_chk(input string tag, input logic [2:0] dest, input logic [15:0] data,
                           input logic [15:0] old_val);
    logic [15:0] cur;
    send(dest, data);
    check({tag, ".ready_n1"}, 32'(wb_ready), 32'd0);
    tick();
    check({tag, ".ready_n2"}, 32'(wb_ready), 32'd0);
    case (dest)
      3'b001:  cur = IR_;
      3'b101:  cur = R5_;
      3'b100:  cur = R1_;
      3'b010:  cur = IDX_;
      default: cur = IDY_;
    endcase
    check({tag, ".not_yet"}, 32'(cur), 32'(old_val));
    tick();
    case (dest)
      3'b001:  cur = IR_;
      3'b101:  cur = R5_;
      3'b100:  cur = R1_;
      3'b010:  cur = IDX_;
      default: cur = IDY_;
    endcase
    check({tag, ".value"}, 32'(cur), 32'(data));
    check({tag, ".ready_back"}, 32'(wb_ready), 32'd1);
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    fails    = 0;
    rst_n    = 1'b0;
    wb_valid = 1'b0;
    WBMUX    = 3'b000;
    wb_data  = 16'h0000;
    inc_idx  = 1'b0;
    inc_idy  = 1'b0;

    // 1 reset
    tick();
    tick();
    check_regs("reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("reset.wr_count", 32'(wr_count), 32'd0);
    check("reset.ready", 32'(wb_ready), 32'd1);
    check("reset.err", 32'(wb_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // 2 legal writes
    write_chk("w_ir",  3'b001, 16'h000F, 16'h0000);
    write_chk("w_r5",  3'b101, 16'h0EF0, 16'h0000);
    write_chk("w_r1",  3'b100, 16'h0FA0, 16'h0000);
    write_chk("w_idx", 3'b010, 16'hF00B, 16'h0000);
    write_chk("w_idy", 3'b011, 16'hCFFC, 16'h0000);
    check("w.wr_count", 32'(wr_count), 32'd5);
    check_regs("w_all", 16'h000F, 16'h0EF0, 16'h0FA0, 16'hF00B, 16'hCFFC);

    // 3 backpressure: valid held high across three words
    WBMUX = 3'b100; wb_data = 16'h1111; wb_valid = 1'b1;
    tick();                                   // edge N: A accepted
    WBMUX = 3'b101; wb_data = 16'h2222;       // B held while busy
    tick();                                   // N+1
    check("bp.r5_untouched", 32'(R5_), 32'h0EF0);
    tick();                                   // N+2: A commits
    check("bp.a_r1", 32'(R1_), 32'h1111);
    check("bp.a_count", 32'(wr_count), 32'd6);
    check("bp.a_ready", 32'(wb_ready), 32'd1);
    tick();                                   // N+3: B accepted
    WBMUX = 3'b001; wb_data = 16'h3333;
    check("bp.b_ready", 32'(wb_ready), 32'd0);
    tick();
    tick();                                   // N+5: B commits
    check("bp.b_r5", 32'(R5_), 32'h2222);
    check("bp.b_count", 32'(wr_count), 32'd7);
    check("bp.ir_before_c", 32'(IR_), 32'h000F);
    tick();                                   // N+6: C accepted
    wb_valid = 1'b0;
    tick();
    tick();                                   // N+8: C commits
    check("bp.c_ir", 32'(IR_), 32'h3333);
    check("bp.c_count", 32'(wr_count), 32'd8);
    tick();
    tick();
    tick();
    check("bp.no_dup_count", 32'(wr_count), 32'd8);
    check_regs("bp_all", 16'h3333, 16'h2222, 16'h1111, 16'hF00B, 16'hCFFC);

    // 4 illegal destination
    send(3'b110, 16'h1234);
    check("ill.err_n1", 32'(wb_err), 32'd0);
    tick();
    check("ill.err_n2_pre", 32'(wb_err), 32'd0);
    tick();
    check("ill.err_pulse", 32'(wb_err), 32'd1);
    check("ill.count", 32'(wr_count), 32'd8);
    tick();
    check("ill.err_clear", 32'(wb_err), 32'd0);
    check_regs("ill", 16'h3333, 16'h2222, 16'h1111, 16'hF00B, 16'hCFFC);

    // 5 increments and commit-vs-increment priority
    write_chk("w_idx_ffff", 3'b010, 16'hFFFF, 16'hF00B);
    inc_idx = 1'b1;
    inc_idy = 1'b1;
    tick();
    inc_idx = 1'b0;
    inc_idy = 1'b0;
    check("inc.idx_wrap", 32'(IDX_), 32'h0000);
    check("inc.idy", 32'(IDY_), 32'hCFFD);
    send(3'b010, 16'h0100);
    tick();                                   // N+1; inc during the commit cycle
    inc_idx = 1'b1;
    tick();                                   // N+2: commit wins
    inc_idx = 1'b0;
    check("inc.commit_wins", 32'(IDX_), 32'h0100);
    check("inc.count", 32'(wr_count), 32'd10);

    // 6 reset during HOLD discards the held word
    send(3'b100, 16'hABCD);
    rst_n = 1'b0;
    tick();
    check_regs("rst_mid", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("rst_mid.ready", 32'(wb_ready), 32'd1);
    check("rst_mid.count", 32'(wr_count), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("rst_mid.r1_never", 32'(R1_), 32'h0000);
    check("rst_mid.count_after", 32'(wr_count), 32'd0);
    check("rst_mid.err", 32'(wb_err), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
